// File: rtl/paillier_job_scheduler_pkg.sv
// Shared Paillier types.
//   paillier_mode_t : operation selector carried by every descriptor
//   paillier_desc_t : queued descriptor {mode, src, dst}; address fields are
//                     64 bits wide, users with narrower buses zero-extend
//   lowest_set_idx  : index of the lowest set bit of a 16-bit vector
package paillier_pkg;

  typedef enum logic [1:0] {
    STA_ENCRYPTION      = 2'd0,
    STA_DECRYPTION      = 2'd1,
    STA_HOMOMORPHIC_ADD = 2'd2,
    STA_SCALAR_MUL      = 2'd3
  } paillier_mode_t;

  typedef struct packed {
    paillier_mode_t mode;
    logic [63:0]    src;
    logic [63:0]    dst;
  } paillier_desc_t;

  // Priority encoder, lowest index wins; returns 0 for an all-zero vector.
  function automatic logic [3:0] lowest_set_idx(input logic [15:0] vec);
    logic [3:0] idx;
    logic       found;
    idx   = 4'd0;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!found && vec[i]) begin
        idx   = 4'(i);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/paillier_job_scheduler_rr_arbiter.sv
// paillier_rr_arbiter: N-way round-robin picker.
//   req_i   : request vector, one bit per requester
//   ptr_i   : index where the search starts (wraps past N-1 to 0)
//   grant_o : one-hot grant of the first requester at or above ptr_i
//   idx_o   : binary index of the granted requester
//   valid_o : at least one request was present
module paillier_rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW:0]   sum_s;
  logic [IW-1:0] cand_s;

  // Walk the requesters from ptr_i upward with wrap, first hit wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    sum_s   = '0;
    cand_s  = '0;
    for (int k = 0; k < N; k++) begin
      sum_s  = {1'b0, ptr_i} + (IW+1)'(k);
      sum_s  = (sum_s >= (IW+1)'(N)) ? (sum_s - (IW+1)'(N)) : sum_s;
      cand_s = sum_s[IW-1:0];
      if (!valid_o && req_i[cand_s]) begin
        valid_o         = 1'b1;
        idx_o           = cand_s;
        grant_o[cand_s] = 1'b1;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/paillier_job_scheduler.sv
// paillier_job_scheduler: queues Paillier descriptors, dispatches them
// round-robin to free engines and returns one completion record at a time.
//   aclk_i / areset_i          : clock, synchronous active-high reset
//   desc_*_i / desc_ready_o    : descriptor push interface (valid/ready)
//   eng_start_o, eng_*_o       : one-hot start pulse plus its descriptor
//   eng_done_i                 : per-engine completion pulses
//   done_*_o / done_ready_i    : completion record (valid/ready)
//   queue_level_o, jobs_done_o : descriptors waiting, reported job count
//   idle_o, err_sticky_o       : nothing outstanding, spurious done seen
module paillier_job_scheduler
  import paillier_pkg::*;
#(
  parameter  int unsigned BLOCK_COUNT = 1,
  parameter  int unsigned DEPTH       = 4,
  parameter  int unsigned ADDR_W      = 64,
  localparam int unsigned ID_W        = (BLOCK_COUNT > 1) ? $clog2(BLOCK_COUNT) : 1,
  localparam int unsigned PTR_W       = $clog2(DEPTH),
  localparam int unsigned LVL_W       = PTR_W + 1
) (
  input  logic                   aclk_i,
  input  logic                   areset_i,
  input  logic                   desc_valid_i,
  output logic                   desc_ready_o,
  input  logic [1:0]             desc_mode_i,
  input  logic [ADDR_W-1:0]      desc_src_addr_i,
  input  logic [ADDR_W-1:0]      desc_dst_addr_i,
  output logic [BLOCK_COUNT-1:0] eng_start_o,
  output logic [1:0]             eng_mode_o,
  output logic [ADDR_W-1:0]      eng_src_addr_o,
  output logic [ADDR_W-1:0]      eng_dst_addr_o,
  input  logic [BLOCK_COUNT-1:0] eng_done_i,
  output logic                   done_valid_o,
  input  logic                   done_ready_i,
  output logic [ID_W-1:0]        done_eng_id_o,
  output logic [ADDR_W-1:0]      done_dst_addr_o,
  output logic [LVL_W-1:0]       queue_level_o,
  output logic [31:0]            jobs_done_o,
  output logic                   idle_o,
  output logic                   err_sticky_o
);

  // Descriptor queue storage and pointers (extra MSB distinguishes full/empty).
  paillier_desc_t          fifo_q [DEPTH];
  logic [PTR_W:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic                    desc_ready_q, desc_ready_d;

  // Engine bookkeeping.
  logic [BLOCK_COUNT-1:0]  inflight_q, inflight_d;
  logic [BLOCK_COUNT-1:0]  pending_q, pending_d;
  logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]       dst_mem_q [BLOCK_COUNT];

  // Registered outputs.
  logic [BLOCK_COUNT-1:0]  eng_start_q, eng_start_d;
  paillier_mode_t          eng_mode_q, eng_mode_d;
  logic [ADDR_W-1:0]       eng_src_q, eng_src_d, eng_dst_q, eng_dst_d;
  logic                    done_valid_q, done_valid_d;
  logic [ID_W-1:0]         done_id_q, done_id_d;
  logic [ADDR_W-1:0]       done_dst_q, done_dst_d;
  logic [31:0]             jobs_done_q, jobs_done_d;
  logic                    idle_q, idle_d;
  logic                    err_q, err_d;

  // Combinational helpers.
  logic                    push_s, empty_s, full_d_s, dispatch_s, hs_s;
  paillier_desc_t          push_desc_s, head_s;
  logic [BLOCK_COUNT-1:0]  grant_s, start_mask_s, hs_mask_s, done_ok_s;
  logic [ID_W-1:0]         gnt_idx_s;
  logic                    gnt_any_s;
  logic [15:0]             pend16_s;

  paillier_rr_arbiter #(.N(BLOCK_COUNT)) u_arb (
    .req_i   (~inflight_q),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant_s),
    .idx_o   (gnt_idx_s),
    .valid_o (gnt_any_s)
  );

  // Next-state computation for queue, engines, records and counters.
  always_comb begin
    push_s           = desc_valid_i & desc_ready_q;
    push_desc_s.mode = paillier_mode_t'(desc_mode_i);
    push_desc_s.src  = 64'(desc_src_addr_i);
    push_desc_s.dst  = 64'(desc_dst_addr_i);
    empty_s          = (wr_ptr_q == rd_ptr_q);
    head_s           = fifo_q[rd_ptr_q[PTR_W-1:0]];

    dispatch_s   = !empty_s & gnt_any_s;
    start_mask_s = dispatch_s ? grant_s : '0;

    hs_s                 = done_valid_q & done_ready_i;
    hs_mask_s            = '0;
    hs_mask_s[done_id_q] = hs_s;

    // A done only counts for an engine that is running and not yet reported.
    done_ok_s = eng_done_i & inflight_q & ~pending_q;
    err_d     = err_q | (|(eng_done_i & ~done_ok_s));

    inflight_d = (inflight_q & ~hs_mask_s) | start_mask_s;
    pending_d  = (pending_q & ~hs_mask_s) | done_ok_s;

    wr_ptr_d     = wr_ptr_q + (PTR_W+1)'(push_s);
    rd_ptr_d     = rd_ptr_q + (PTR_W+1)'(dispatch_s);
    level_d      = level_q + LVL_W'(push_s) - LVL_W'(dispatch_s);
    full_d_s     = (wr_ptr_d[PTR_W] != rd_ptr_d[PTR_W]) &&
                   (wr_ptr_d[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]);
    desc_ready_d = !full_d_s;

    if (dispatch_s) begin
      rr_ptr_d   = (gnt_idx_s == ID_W'(BLOCK_COUNT - 1)) ? '0 : (gnt_idx_s + ID_W'(1));
      eng_mode_d = head_s.mode;
      eng_src_d  = ADDR_W'(head_s.src);
      eng_dst_d  = ADDR_W'(head_s.dst);
    end else begin
      rr_ptr_d   = rr_ptr_q;
      eng_mode_d = eng_mode_q;
      eng_src_d  = eng_src_q;
      eng_dst_d  = eng_dst_q;
    end
    eng_start_d = start_mask_s;

    // An offered record is frozen until it is consumed; otherwise present
    // the lowest-index pending engine, including completions from this cycle.
    pend16_s                   = 16'h0000;
    pend16_s[BLOCK_COUNT-1:0]  = pending_d;
    if (done_valid_q && !done_ready_i) begin
      done_valid_d = done_valid_q;
      done_id_d    = done_id_q;
      done_dst_d   = done_dst_q;
    end else begin
      done_valid_d = |pending_d;
      done_id_d    = ID_W'(lowest_set_idx(pend16_s));
      done_dst_d   = dst_mem_q[done_id_d];
    end

    jobs_done_d = jobs_done_q + (hs_s ? 32'd1 : 32'd0);
    idle_d      = (level_d == '0) && (inflight_d == '0) && (pending_d == '0);
  end

  // Control and output registers.
  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      desc_ready_q <= 1'b0;
      inflight_q   <= '0;
      pending_q    <= '0;
      rr_ptr_q     <= '0;
      eng_start_q  <= '0;
      eng_mode_q   <= STA_ENCRYPTION;
      eng_src_q    <= '0;
      eng_dst_q    <= '0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      done_dst_q   <= '0;
      jobs_done_q  <= 32'd0;
      idle_q       <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      desc_ready_q <= desc_ready_d;
      inflight_q   <= inflight_d;
      pending_q    <= pending_d;
      rr_ptr_q     <= rr_ptr_d;
      eng_start_q  <= eng_start_d;
      eng_mode_q   <= eng_mode_d;
      eng_src_q    <= eng_src_d;
      eng_dst_q    <= eng_dst_d;
      done_valid_q <= done_valid_d;
      done_id_q    <= done_id_d;
      done_dst_q   <= done_dst_d;
      jobs_done_q  <= jobs_done_d;
      idle_q       <= idle_d;
      err_q        <= err_d;
    end
  end

  // Queue payload write; contents are only read behind valid pointers.
  always_ff @(posedge aclk_i) begin
    if (push_s) begin
      fifo_q[wr_ptr_q[PTR_W-1:0]] <= push_desc_s;
    end
  end

  // Remember each dispatched job's destination for its completion record.
  always_ff @(posedge aclk_i) begin
    if (dispatch_s) begin
      dst_mem_q[gnt_idx_s] <= ADDR_W'(head_s.dst);
    end
  end

  assign desc_ready_o    = desc_ready_q;
  assign eng_start_o     = eng_start_q;
  assign eng_mode_o      = eng_mode_q;
  assign eng_src_addr_o  = eng_src_q;
  assign eng_dst_addr_o  = eng_dst_q;
  assign done_valid_o    = done_valid_q;
  assign done_eng_id_o   = done_id_q;
  assign done_dst_addr_o = done_dst_q;
  assign queue_level_o   = level_q;
  assign jobs_done_o     = jobs_done_q;
  assign idle_o          = idle_q;
  assign err_sticky_o    = err_q;

endmodule

// File: tb/tb_paillier_job_scheduler.sv
// Self-checking bench for paillier_job_scheduler with four engines.
module tb_paillier_job_scheduler;

  localparam int N = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        desc_valid = 1'b0;
  logic        desc_ready;
  logic [1:0]  desc_mode = 2'd0;
  logic [63:0] desc_src = 64'd0, desc_dst = 64'd0;
  logic [3:0]  eng_start;
  logic [1:0]  eng_mode;
  logic [63:0] eng_src, eng_dst;
  logic [3:0]  eng_done = 4'd0;
  logic        done_valid;
  logic        done_ready = 1'b0;
  logic [1:0]  done_eng_id;
  logic [63:0] done_dst;
  logic [2:0]  queue_level;
  logic [31:0] jobs_done;
  logic        idle, err_sticky;

  int checks = 0;
  int failures = 0;

  paillier_job_scheduler #(.BLOCK_COUNT(N), .DEPTH(D), .ADDR_W(64)) dut (
    .aclk_i(clk), .areset_i(areset),
    .desc_valid_i(desc_valid), .desc_ready_o(desc_ready), .desc_mode_i(desc_mode),
    .desc_src_addr_i(desc_src), .desc_dst_addr_i(desc_dst),
    .eng_start_o(eng_start), .eng_mode_o(eng_mode),
    .eng_src_addr_o(eng_src), .eng_dst_addr_o(eng_dst), .eng_done_i(eng_done),
    .done_valid_o(done_valid), .done_ready_i(done_ready), .done_eng_id_o(done_eng_id),
    .done_dst_addr_o(done_dst), .queue_level_o(queue_level), .jobs_done_o(jobs_done),
    .idle_o(idle), .err_sticky_o(err_sticky)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic [1:0]  mode;
    logic [63:0] src;
    logic [63:0] dst;
  } mdesc_t;

  mdesc_t      q_m[$];
  bit          m_infl [N];
  bit          m_pend [N];
  logic [63:0] m_dstm [N];
  int          m_rr;
  logic [31:0] m_jobs;
  bit          m_err;
  bit          e_ready, e_dv, e_idle;
  logic [3:0]  e_start;
  logic [1:0]  e_mode;
  logic [63:0] e_src, e_dst, e_ddst;
  int          e_id;
  bit          busy [N];

  task automatic model_reset();
    q_m.delete();
    for (int i = 0; i < N; i++) begin
      m_infl[i] = 1'b0; m_pend[i] = 1'b0; m_dstm[i] = 64'd0; busy[i] = 1'b0;
    end
    m_rr = 0; m_jobs = 32'd0; m_err = 1'b0;
    e_ready = 1'b0; e_dv = 1'b0; e_idle = 1'b1;
    e_start = 4'd0; e_mode = 2'd0; e_src = 64'd0; e_dst = 64'd0;
    e_ddst = 64'd0; e_id = 0;
  endtask

  // One clock of the scheduler's rules, applied to the inputs present at the edge.
  task automatic model_step();
    bit     push, hs, found;
    int     hid, eidx, low;
    bit     ok [N];
    mdesc_t d;
    if (areset) begin
      model_reset();
    end else begin
      push = desc_valid && e_ready;
      hs   = e_dv && done_ready;
      hid  = e_id;
      eidx = -1;
      if (q_m.size() > 0)
        for (int k = 0; k < N; k++)
          if (eidx < 0 && !m_infl[(m_rr + k) % N]) eidx = (m_rr + k) % N;
      for (int i = 0; i < N; i++) begin
        ok[i] = eng_done[i] && m_infl[i] && !m_pend[i];
        if (eng_done[i] && !ok[i]) m_err = 1'b1;
      end
      if (hs) begin
        m_pend[hid] = 1'b0; m_infl[hid] = 1'b0; m_jobs = m_jobs + 32'd1;
      end
      for (int i = 0; i < N; i++) if (ok[i]) m_pend[i] = 1'b1;
      if (eidx >= 0) begin
        d = q_m.pop_front();
        e_start = 4'(1 << eidx);
        e_mode = d.mode; e_src = d.src; e_dst = d.dst;
        m_dstm[eidx] = d.dst; m_infl[eidx] = 1'b1;
        m_rr = (eidx + 1) % N;
      end else begin
        e_start = 4'd0;
      end
      if (push) begin
        d.mode = desc_mode; d.src = desc_src; d.dst = desc_dst;
        q_m.push_back(d);
      end
      if (!(e_dv && !done_ready)) begin
        low = -1;
        for (int i = 0; i < N; i++) if (low < 0 && m_pend[i]) low = i;
        e_dv = (low >= 0);
        if (low >= 0) begin e_id = low; e_ddst = m_dstm[low]; end
      end
      e_ready = (q_m.size() < D);
      found = 1'b0;
      for (int i = 0; i < N; i++) if (m_infl[i] || m_pend[i]) found = 1'b1;
      e_idle = (q_m.size() == 0) && !found;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("desc_ready", 64'(desc_ready), 64'(e_ready));
    chk("eng_start", 64'(eng_start), 64'(e_start));
    chk("eng_mode", 64'(eng_mode), 64'(e_mode));
    chk("eng_src", eng_src, e_src);
    chk("eng_dst", eng_dst, e_dst);
    chk("done_valid", 64'(done_valid), 64'(e_dv));
    if (e_dv) begin
      chk("done_eng_id", 64'(done_eng_id), 64'(e_id));
      chk("done_dst", done_dst, e_ddst);
    end
    chk("queue_level", 64'(queue_level), 64'(q_m.size()));
    chk("jobs_done", 64'(jobs_done), 64'(m_jobs));
    chk("idle", 64'(idle), 64'(e_idle));
    chk("err_sticky", 64'(err_sticky), 64'(m_err));
  endtask

  // Advance one edge, compare against the model 1 ns later, end done pulses.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    for (int i = 0; i < N; i++) if (e_start[i]) busy[i] = 1'b1;
    eng_done = 4'd0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    tick();
  endtask

  task automatic set_desc(input logic [1:0] m, input logic [63:0] s, input logic [63:0] t);
    desc_valid = 1'b1; desc_mode = m; desc_src = s; desc_dst = t;
  endtask

  initial begin
    model_reset();
    // Reset behaviour: not ready in reset and in the first cycle after it.
    tick(); tick();
    chk("rst_ready_in_reset", 64'(desc_ready), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    areset = 1'b0;
    #1;
    chk("ready_first_cycle", 64'(desc_ready), 64'd0);
    tick();
    chk("ready_after_reset", 64'(desc_ready), 64'd1);

    // Single encryption job end to end.
    set_desc(2'd0, 64'h1000, 64'h2000);
    tick();
    desc_valid = 1'b0;
    chk("start_not_same_edge", 64'(eng_start), 64'd0);
    tick();
    chk("start_eng0", 64'(eng_start), 64'h1);
    chk("start_mode", 64'(eng_mode), 64'd0);
    chk("start_src", eng_src, 64'h1000);
    chk("start_dst", eng_dst, 64'h2000);
    tick();
    eng_done = 4'b0001;
    tick();
    chk("rec_valid", 64'(done_valid), 64'd1);
    chk("rec_id", 64'(done_eng_id), 64'd0);
    chk("rec_dst", done_dst, 64'h2000);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk("jobs_one", 64'(jobs_done), 64'd1);
    chk("idle_back", 64'(idle), 64'd1);

    // Four back-to-back descriptors spread over engines 0..3.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_desc(2'(k), 64'h10000 + 64'(k), 64'h20000 + 64'(k));
      tick();
      if (k >= 1) chk("rr_start", 64'(eng_start), 64'(4'b0001 << (k - 1)));
    end
    set_desc(2'd3, 64'h10004, 64'h20004);
    tick();
    chk("rr_start3", 64'(eng_start), 64'h8);
    desc_valid = 1'b0;
    tick();
    chk("fifth_queued", 64'(queue_level), 64'd1);
    for (int k = 5; k < 8; k++) begin
      set_desc(2'd1, 64'h10000 + 64'(k), 64'h20000 + 64'(k));
      tick();
    end
    chk("full_level", 64'(queue_level), 64'd4);
    chk("full_not_ready", 64'(desc_ready), 64'd0);
    // Held descriptor plus simultaneous completions on engines 2 and 0.
    set_desc(2'd2, 64'h1BEEF, 64'h2BEEF);
    eng_done = 4'b0101;
    tick();
    chk("held_level", 64'(queue_level), 64'd4);
    chk("rec0_id", 64'(done_eng_id), 64'd0);
    chk("rec0_dst", done_dst, 64'h20000);
    tick(); tick();
    chk("rec0_stable", 64'(done_eng_id), 64'd0);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk("rec2_id", 64'(done_eng_id), 64'd2);
    chk("rec2_dst", done_dst, 64'h20002);
    tick();
    chk("redispatch_eng0", 64'(eng_start), 64'h1);
    chk("level_after_pop", 64'(queue_level), 64'd3);
    tick();
    chk("held_accepted", 64'(queue_level), 64'd4);
    desc_valid = 1'b0;
    tick();

    // Spurious completion, reset with jobs in flight, late done after reset.
    do_reset();
    eng_done = 4'b0010;
    tick();
    chk("spurious_err", 64'(err_sticky), 64'd1);
    chk("spurious_no_rec", 64'(done_valid), 64'd0);
    set_desc(2'd3, 64'h3000, 64'h4000);
    tick(); tick();
    desc_valid = 1'b0;
    tick();
    areset = 1'b1;
    tick();
    chk("r_ready", 64'(desc_ready), 64'd0);
    chk("r_start", 64'(eng_start), 64'd0);
    chk("r_mode", 64'(eng_mode), 64'd0);
    chk("r_src", eng_src, 64'd0);
    chk("r_dst", eng_dst, 64'd0);
    chk("r_valid", 64'(done_valid), 64'd0);
    chk("r_id", 64'(done_eng_id), 64'd0);
    chk("r_ddst", done_dst, 64'd0);
    chk("r_level", 64'(queue_level), 64'd0);
    chk("r_jobs", 64'(jobs_done), 64'd0);
    chk("r_idle", 64'(idle), 64'd1);
    chk("r_err", 64'(err_sticky), 64'd0);
    areset = 1'b0;
    eng_done = 4'b0001;
    tick();
    chk("late_done_err", 64'(err_sticky), 64'd1);

    // Job counter wrap.
    do_reset();
    set_desc(2'd2, 64'h5000, 64'h6000);
    tick();
    desc_valid = 1'b0;
    tick();
    eng_done = 4'b0001;
    tick();
    force dut.jobs_done_q = 32'hFFFF_FFFF;
    #1;
    release dut.jobs_done_q;
    m_jobs = 32'hFFFF_FFFF;
    chk("jobs_preload", 64'(jobs_done), 64'hFFFF_FFFF);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk("jobs_wrap", 64'(jobs_done), 64'd0);

    // Randomised traffic against the model.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 599) == 0) begin
        areset = 1'b1;
        desc_valid = 1'b0;
      end else begin
        areset = 1'b0;
        desc_valid = ($urandom_range(0, 1) == 1);
        desc_mode  = 2'($urandom_range(0, 3));
        desc_src   = {$urandom, $urandom};
        desc_dst   = {$urandom, $urandom};
        done_ready = ($urandom_range(0, 9) < 6);
        for (int i = 0; i < N; i++)
          if (busy[i] && $urandom_range(0, 4) == 0) begin
            eng_done[i] = 1'b1;
            busy[i] = 1'b0;
          end
        if ($urandom_range(0, 249) == 0) eng_done[$urandom_range(0, N - 1)] = 1'b1;
      end
      tick();
    end
    areset = 1'b0;
    desc_valid = 1'b0;
    done_ready = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/paillier_job_scheduler.md
# paillier_job_scheduler

Dispatches Paillier operation descriptors (encryption, decryption, homomorphic add, scalar multiply) to `BLOCK_COUNT` parallel Paillier engine instances inside `paillier_axi_top`. Sits between the AXI-lite register file, which pushes descriptors, and the engine array. It queues descriptors, assigns each one round-robin to a free engine, and returns per-job completion records to the register file and interrupt logic.

## Interface
- `BLOCK_COUNT`, 1: number of engines, 1..16.
- `DEPTH`, 4: descriptor queue depth, power of two, ≥2.
- `ADDR_W`, 64: source/destination address width.
- `ACLK  in  1  clock`
- `ARESET  in  1  reset, synchronous, active-high`
- `desc_valid  in  1  descriptor offered`
- `desc_ready  out  1  queue can accept`
- `desc_mode  in  2  0 enc, 1 dec, 2 hom-add, 3 scalar-mul`
- `desc_src_addr  in  ADDR_W  operand base`
- `desc_dst_addr  in  ADDR_W  result base`
- `eng_start  out  BLOCK_COUNT  one-hot one-cycle start pulse`
- `eng_mode  out  2  mode for the started engine, valid with eng_start`
- `eng_src_addr / eng_dst_addr  out  ADDR_W  valid with eng_start`
- `eng_done  in  BLOCK_COUNT  per-engine one-cycle completion pulse`
- `done_valid  out  1  completion record available`
- `done_ready  in  1  record consumed`
- `done_eng_id  out  $clog2(BLOCK_COUNT) (min 1)  engine that finished`
- `done_dst_addr  out  ADDR_W  result base of finished job`
- `queue_level  out  $clog2(DEPTH)+1  descriptors waiting`
- `jobs_done  out  32  completed-and-reported job count, wraps`
- `idle  out  1  queue empty, no engine in flight, no pending record`
- `err_sticky  out  1  spurious eng_done seen; cleared only by reset`

## Operation
- Descriptor queue: a FIFO of {mode, src, dst}. `desc_ready = !full`, computed from the registered level. A push is taken on `desc_valid & desc_ready`. A pop in the same cycle does not free space for that cycle's push.
- `inflight[i]` is set when engine i is started. It clears only when that engine's completion record is handshaken. An engine is never restarted before its result is reported.
- `pending[i]` is set on `eng_done[i]` while `inflight[i]`.
- `eng_done[i]` with `!inflight[i]` or with `pending[i]` already set is ignored and sets `err_sticky`.
- Dispatch happens each cycle when the queue is non-empty and `~inflight` is non-zero:
  - Pick the first free engine searching upward from `rr_ptr`, with wrap-around.
  - Register `eng_start`, `eng_mode`, `eng_src_addr`, `eng_dst_addr` and pop the queue.
  - Store the destination address in `dst_mem[i]`.
  - Set `rr_ptr` to the chosen index + 1, mod `BLOCK_COUNT`.
  - At most one dispatch per cycle.
- Completion: `done_valid = |pending`. The record is for the lowest-index pending engine, `done_dst_addr = dst_mem[id]`. Records are held stable until `done_ready`.
- On the completion handshake: clear `pending[id]` and `inflight[id]`, and increment `jobs_done` (32-bit wrap, 0xFFFFFFFF→0).
- No mode filtering: all four modes are forwarded unchanged.
- Reset mid-operation: queue, `inflight`, `pending`, `rr_ptr`, counters and `err_sticky` all clear. Engine state is the parent's responsibility. A late `eng_done` after reset is treated as spurious.

## Timing
- Reset values:
  - `desc_ready` = 1 (the cycle after reset deasserts; 0 while `ARESET` is high).
  - `eng_start` = 0, `eng_mode`/`eng_src_addr`/`eng_dst_addr` = 0.
  - `done_valid` = 0, `done_eng_id` = 0, `done_dst_addr` = 0.
  - `queue_level` = 0, `jobs_done` = 0, `idle` = 1, `err_sticky` = 0.
- Accept at cycle t → earliest `eng_start` at t+1 (the queue is read combinationally and the start is registered).
- `eng_done` at t → `done_valid` at t+1.
- Handshake at t → the engine is eligible for dispatch at t+1. `jobs_done` shows the increment at t+1.
- Sustained throughput: one dispatch per cycle while engines are free.
- A done pulse and the handshake of a different engine in the same cycle are both honoured.

## Structure
- Shared `paillier_pkg`:
  - `paillier_mode_t` enum: `STA_ENCRYPTION`, `STA_DECRYPTION`, `STA_HOMOMORPHIC_ADD`, `STA_SCALAR_MUL`.
  - `paillier_desc_t` struct: mode, src, dst.
- Sub-module `paillier_rr_arbiter`: parameterised N-way round-robin picker (request vector + pointer → one-hot grant + index). Reused later for AXI master sharing.
- The FIFO is inline: registered array with read/write pointers and an extra wrap bit.

## Test plan
- Reset, then push enc descriptor (src 0x1000, dst 0x2000), `BLOCK_COUNT`=1 → `eng_start`=1 at t+1 with mode 0. Pulse `eng_done` → `done_valid` with id 0, dst 0x2000. Handshake → `jobs_done`=1, `idle`=1.
- `BLOCK_COUNT`=4, push 4 descriptors back-to-back → starts on engines 0,1,2,3 in consecutive cycles. A fifth descriptor stays queued (`queue_level`=1) until a record is consumed.
- `DEPTH`=4 with all engines busy, push 4 → `desc_ready`=0. A fifth `desc_valid` is held, not lost, and accepted the cycle after the first pop.
- `eng_done` on engines 2 and 0 in the same cycle → records reported id 0 then id 2 with their stored dst addresses. `done_ready` held low keeps the record stable.
- `eng_done[1]` with engine 1 idle → `err_sticky`=1, `done_valid` stays 0. Assert `ARESET` with jobs in flight → all outputs at reset values the next cycle.
- Preload `jobs_done` path by 2^32 handshakes (force) → wraps to 0.
